// File: rtl/evm_booth_arbiter.sv
// Round-robin arbiter that lets polling booths take turns driving a single EVM ballot.
// Every output is decoded from the registered state, so nothing combinational reaches the EVM.
module evm_booth_arbiter #(
  parameter int NUM_BOOTHS = 4,
  parameter int TIMEOUT    = 100
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    session_open,
  input  logic [NUM_BOOTHS-1:0]   booth_req,
  input  logic [2*NUM_BOOTHS-1:0] booth_vote,
  output logic [NUM_BOOTHS-1:0]   booth_grant,
  output logic [NUM_BOOTHS-1:0]   booth_ack,
  output logic [NUM_BOOTHS-1:0]   booth_reject,
  output logic                    evm_candidate_ready,
  output logic                    evm_vote_1,
  output logic                    evm_vote_2,
  output logic                    evm_vote_3,
  input  logic                    evm_voting_in_progress,
  input  logic                    evm_voting_done,
  output logic [7:0]              votes_cast,
  output logic                    busy
);

  localparam int IW = $clog2(NUM_BOOTHS);

  typedef enum logic [2:0] {
    S_IDLE, S_ARBITRATE, S_READY, S_WAIT_PROGRESS,
    S_WAIT_VOTE, S_DRIVE_VOTE, S_RELEASE, S_CLOSED
  } state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] winner;
  logic [IW-1:0] rr_pick;
  logic [6:0]    timer;
  logic [1:0]    code;
  logic [1:0]    winner_code;
  logic          acked;
  logic          winner_req;

  // Scan from the highest offset down so the booth closest to the pointer wins.
  always_comb begin
    rr_pick = ptr;
    for (int i = NUM_BOOTHS - 1; i >= 0; i--) begin
      if (booth_req[IW'(ptr + IW'(i))]) rr_pick = IW'(ptr + IW'(i));
    end
  end

  assign winner_code = booth_vote[{winner, 1'b0} +: 2];
  assign winner_req  = booth_req[winner];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      ptr        <= '0;
      winner     <= '0;
      timer      <= '0;
      code       <= '0;
      acked      <= 1'b0;
      votes_cast <= '0;
    end else begin
      // The ack/reject pulse is already visible in RELEASE, so its bookkeeping is never skipped.
      if (state == S_RELEASE) begin
        ptr <= winner + 1'b1;
        if (acked && votes_cast != 8'hFF) votes_cast <= votes_cast + 8'd1;
      end

      if (!session_open) begin
        state <= S_IDLE;
      end else if (evm_voting_done && state != S_IDLE) begin
        state <= S_CLOSED;
      end else begin
        case (state)
          S_IDLE: begin
            state      <= S_ARBITRATE;
            votes_cast <= '0;
            ptr        <= '0;
          end
          S_ARBITRATE: begin
            if (|booth_req) begin
              winner <= rr_pick;
              state  <= S_READY;
            end
          end
          S_READY: begin
            if (!winner_req) begin
              ptr   <= winner + 1'b1;
              state <= S_ARBITRATE;
            end else begin
              timer <= '0;
              state <= S_WAIT_PROGRESS;
            end
          end
          S_WAIT_PROGRESS: begin
            if (!winner_req) begin
              ptr   <= winner + 1'b1;
              state <= S_ARBITRATE;
            end else if (evm_voting_in_progress) begin
              state <= S_WAIT_VOTE;
            end
          end
          S_WAIT_VOTE: begin
            if (!winner_req) begin
              ptr   <= winner + 1'b1;
              state <= S_ARBITRATE;
            end else if (winner_code != 2'b00) begin
              code  <= winner_code;
              state <= S_DRIVE_VOTE;
            end else begin
              timer <= timer + 7'd1;
              if (timer == 7'(TIMEOUT - 1)) begin
                acked <= 1'b0;
                state <= S_RELEASE;
              end
            end
          end
          S_DRIVE_VOTE: begin
            acked <= 1'b1;
            state <= S_RELEASE;
          end
          S_RELEASE: state <= S_ARBITRATE;
          S_CLOSED:  state <= S_CLOSED;
          default:   state <= S_IDLE;
        endcase
      end
    end
  end

  logic holding;
  assign holding = state inside {S_READY, S_WAIT_PROGRESS, S_WAIT_VOTE, S_DRIVE_VOTE};

  assign booth_grant         = holding ? (NUM_BOOTHS'(1) << winner) : '0;
  assign booth_ack           = (state == S_RELEASE && acked) ? (NUM_BOOTHS'(1) << winner) : '0;
  assign booth_reject        = (state == S_RELEASE && !acked) ? (NUM_BOOTHS'(1) << winner) : '0;
  assign evm_candidate_ready = (state == S_READY);
  assign evm_vote_1          = (state == S_DRIVE_VOTE) && (code == 2'd1);
  assign evm_vote_2          = (state == S_DRIVE_VOTE) && (code == 2'd2);
  assign evm_vote_3          = (state == S_DRIVE_VOTE) && (code == 2'd3);
  assign busy                = (state != S_IDLE) && (state != S_CLOSED);

endmodule

// File: tb/tb_evm_booth_arbiter.sv
// Directed and randomized ballots for evm_booth_arbiter, checked against a
// transaction-level model of grant order, vote forwarding and the vote tally.
module tb_evm_booth_arbiter;

  logic       clk;
  logic       rst;
  logic       session_open;
  logic [3:0] booth_req;
  logic [7:0] booth_vote;
  logic [3:0] booth_grant, booth_ack, booth_reject;
  logic       evm_candidate_ready, evm_vote_1, evm_vote_2, evm_vote_3;
  logic       evm_voting_in_progress, evm_voting_done;
  logic [7:0] votes_cast;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int ptr_m    = 0;
  int votes_m  = 0;

  evm_booth_arbiter #(.NUM_BOOTHS(4), .TIMEOUT(100)) dut (
    .clk(clk), .rst(rst), .session_open(session_open),
    .booth_req(booth_req), .booth_vote(booth_vote),
    .booth_grant(booth_grant), .booth_ack(booth_ack), .booth_reject(booth_reject),
    .evm_candidate_ready(evm_candidate_ready),
    .evm_vote_1(evm_vote_1), .evm_vote_2(evm_vote_2), .evm_vote_3(evm_vote_3),
    .evm_voting_in_progress(evm_voting_in_progress),
    .evm_voting_done(evm_voting_done),
    .votes_cast(votes_cast), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // First requesting booth at or after the pointer, walking around the ring.
  function automatic int rr_pick(input logic [3:0] req, input int p);
    for (int k = 0; k < 4; k++) begin
      if (req[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_grant();
    int n;
    n = 0;
    while (booth_grant == 4'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  // One complete ballot; code 0 means the booth never votes and must time out.
  task automatic applyStimulus(input logic [3:0] req, input logic [1:0] code,
                               input int prog_delay, input int vote_delay);
    int w, n, spurious;
    logic [2:0] pulses;
    booth_req = req;
    w = rr_pick(req, ptr_m);
    wait_grant();
    checkOutput("grant", booth_grant, 32'(4'b1 << w));
    checkOutput("cand_ready", evm_candidate_ready, 1);
    booth_vote = 8'($urandom);
    booth_vote[2*w +: 2] = 2'b00;
    repeat (prog_delay) @(negedge clk);
    evm_voting_in_progress = 1'b1;
    if (code != 2'b00) begin
      repeat (vote_delay) @(negedge clk);
      booth_vote[2*w +: 2] = code;
      n = 0;
      pulses = 3'b0;
      while (pulses == 3'b0 && n < 20) begin
        @(negedge clk);
        n++;
        pulses = {evm_vote_3, evm_vote_2, evm_vote_1};
      end
      checkOutput("vote_pulse", pulses, 32'(3'b1 << (code - 2'd1)));
      checkOutput("ready_vs_vote", evm_candidate_ready, 0);
      @(negedge clk);
      checkOutput("ack", booth_ack, 32'(4'b1 << w));
      checkOutput("vote_one_cycle", {evm_vote_3, evm_vote_2, evm_vote_1}, 0);
      votes_m = (votes_m < 255) ? votes_m + 1 : 255;
    end else begin
      n = 0;
      spurious = 0;
      while (booth_reject == 4'b0 && n < 150) begin
        @(negedge clk);
        n++;
        if ({evm_vote_3, evm_vote_2, evm_vote_1} != 3'b0 || booth_ack != 4'b0) spurious++;
      end
      checkOutput("reject", booth_reject, 32'(4'b1 << w));
      checkOutput("timeout_cycles", n, (prog_delay == 0) ? 102 : 101);
      checkOutput("no_vote_on_timeout", spurious, 0);
    end
    ptr_m = (w + 1) % 4;
    booth_vote = 8'h00;
    evm_voting_in_progress = 1'b0;
    @(negedge clk);
    checkOutput("votes_cast", votes_cast, votes_m);
    checkOutput("busy_arbitrate", busy, 1);
  endtask

  initial begin
    int w, n, spurious;
    logic [7:0] held_votes;
    rst = 1'b1;
    session_open = 1'b0;
    booth_req = 4'b0;
    booth_vote = 8'h00;
    evm_voting_in_progress = 1'b0;
    evm_voting_done = 1'b0;
    #1 rst = 1'b0;
    #2;
    checkOutput("rst_grant", booth_grant, 0);
    checkOutput("rst_ack_rej", {booth_ack, booth_reject}, 0);
    checkOutput("rst_evm", {evm_candidate_ready, evm_vote_1, evm_vote_2, evm_vote_3}, 0);
    checkOutput("rst_votes", votes_cast, 0);
    checkOutput("rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    session_open = 1'b1;
    @(negedge clk);
    checkOutput("busy_after_open", busy, 1);

    // Single booth, candidate 2.
    applyStimulus(4'b0001, 2'b10, 1, 0);

    // Closing and reopening the session restarts the tally and pointer.
    session_open = 1'b0;
    @(negedge clk);
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_votes_kept", votes_cast, 1);
    session_open = 1'b1;
    @(negedge clk);
    ptr_m = 0;
    votes_m = 0;
    checkOutput("reopen_votes_clear", votes_cast, 0);

    // All booths requesting: grant order 0,1,2,3,0.
    for (int i = 0; i < 5; i++)
      applyStimulus(4'b1111, 2'($urandom_range(1, 3)), $urandom_range(0, 2), $urandom_range(0, 3));
    checkOutput("five_votes", votes_cast, 5);

    // Booth 2 times out, then booth 3 is next.
    applyStimulus(4'b0100, 2'b00, 1, 0);
    applyStimulus(4'b1111, 2'b01, 0, 0);

    // Winner withdraws while waiting for the EVM.
    booth_req = 4'b1010;
    w = rr_pick(4'b1010, ptr_m);
    wait_grant();
    checkOutput("abort_grant", booth_grant, 32'(4'b1 << w));
    @(negedge clk);
    booth_req = 4'b0000;
    @(negedge clk);
    checkOutput("abort_grant_drop", booth_grant, 0);
    checkOutput("abort_no_pulse", {booth_ack, booth_reject}, 0);
    ptr_m = (w + 1) % 4;
    applyStimulus(4'b1111, 2'b11, 2, 1);

    // EVM closes mid-ballot.
    held_votes = votes_cast;
    booth_req = 4'b0001;
    wait_grant();
    @(negedge clk);
    evm_voting_in_progress = 1'b1;
    @(negedge clk);
    checkOutput("wait_vote_grant", booth_grant, 32'b0001);
    evm_voting_done = 1'b1;
    @(negedge clk);
    checkOutput("closed_grant", booth_grant, 0);
    checkOutput("closed_busy", busy, 0);
    checkOutput("closed_no_pulse", {booth_ack, booth_reject, evm_vote_1, evm_vote_2, evm_vote_3}, 0);
    evm_voting_done = 1'b0;
    evm_voting_in_progress = 1'b0;
    booth_req = 4'b0000;
    @(negedge clk);
    checkOutput("closed_stays", busy, 0);
    checkOutput("closed_votes_held", votes_cast, 32'(held_votes));
    session_open = 1'b0;
    @(negedge clk);
    checkOutput("closed_to_idle_busy", busy, 0);

    // Long random run drives the tally into saturation.
    session_open = 1'b1;
    @(negedge clk);
    ptr_m = 0;
    votes_m = 0;
    for (int i = 0; i < 260; i++)
      applyStimulus(4'($urandom_range(1, 15)), 2'($urandom_range(1, 3)),
                    $urandom_range(0, 2), $urandom_range(0, 3));
    checkOutput("votes_saturated", votes_cast, 255);

    // Asynchronous reset while a vote is being driven.
    booth_req = 4'b0001;
    wait_grant();
    evm_voting_in_progress = 1'b1;
    booth_vote = 8'b0000_0011;
    n = 0;
    while ({evm_vote_3, evm_vote_2, evm_vote_1} == 3'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("pre_reset_vote3", {evm_vote_3, evm_vote_2, evm_vote_1}, 32'b100);
    rst = 1'b0;
    #1;
    checkOutput("async_rst_outputs",
                {booth_grant, booth_ack, booth_reject, evm_candidate_ready,
                 evm_vote_1, evm_vote_2, evm_vote_3, busy}, 0);
    checkOutput("async_rst_votes", votes_cast, 0);
    booth_req = 4'b0000;
    booth_vote = 8'h00;
    evm_voting_in_progress = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    spurious = 0;
    repeat (4) begin
      @(negedge clk);
      if ({booth_ack, booth_reject, evm_vote_1, evm_vote_2, evm_vote_3} != 0) spurious++;
    end
    checkOutput("no_pulse_after_reset", spurious, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
